// File: rtl/stream_opcode_decoder_if.sv
// Handshake bundle for stream_opcode_decoder.
//   in_valid/in_ready/in_byte   : instruction byte stream from the fetch buffer
//   out_valid/out_ready         : decoded-record handshake toward control/execute
//   op_onehot/op_index/a_field/imm/illegal : decoded record fields
// master = stream producer / record consumer, slave = the decoder.
interface stream_opcode_decoder_if #(
  parameter int unsigned IMM_BYTES = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_byte;
  logic                   out_valid;
  logic                   out_ready;
  logic [22:0]            op_onehot;
  logic [4:0]             op_index;
  logic [3:0]             a_field;
  logic [8*IMM_BYTES-1:0] imm;
  logic                   illegal;

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, op_onehot, op_index, a_field, imm, illegal
  );

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, op_onehot, op_index, a_field, imm, illegal
  );
endinterface

// File: rtl/stream_opcode_decoder.sv
// Byte-stream instruction decoder. Accepts opcode bytes (plus trailing little-endian
// immediate bytes for majors selected by IMM_MASK), decodes the opcode into a 23-line
// one-hot control vector and emits one registered record per instruction.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus_io : slave side of stream_opcode_decoder_if (byte stream in, record out)
module stream_opcode_decoder #(
  parameter logic [15:0] IMM_MASK  = 16'h0000,
  parameter int unsigned IMM_BYTES = 1,
  parameter bit          STRICT    = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  stream_opcode_decoder_if.slave      bus_io
);

  localparam int unsigned CntW = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(IMM_BYTES - 1);

  typedef enum logic [1:0] {StOpc, StImm, StOut} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [4:0]             idx_q, idx_d;
  logic [22:0]            onehot_q, onehot_d;
  logic [3:0]             a_q, a_d;
  logic [8*IMM_BYTES-1:0] imm_q, imm_d;
  logic                   ill_q, ill_d;
  logic                   in_fire;
  logic                   load_opc;

  function automatic logic [4:0] decode_idx(input logic [7:0] b);
    logic [4:0] maj5;
    logic [4:0] r;
    maj5 = {1'b0, b[7:4]};
    if (b[7:4] == 4'd0)        r = 5'd0;
    else if (b[7:4] == 4'd1)   r = 5'd1 + {3'b000, b[1:0]};
    else if (b[7:4] <= 4'd11)  r = maj5 + 5'd3;
    else if (b[7:4] == 4'd12)  r = 5'd15 + {4'b0000, b[0]};
    else if (b[7:4] <= 4'd14)  r = maj5 + 5'd4;
    else                       r = 5'd19 + {3'b000, b[1:0]};
    return r;
  endfunction

  // Expanded majors only define some low bits; the rest must be zero in strict mode.
  function automatic logic decode_ill(input logic [7:0] b);
    logic r;
    r = 1'b0;
    if ((b[7:4] == 4'd1) || (b[7:4] == 4'd15)) r = (b[3:2] != 2'b00);
    else if (b[7:4] == 4'd12)                  r = (b[3:1] != 3'b000);
    return STRICT & r;
  endfunction

  // While a record is held, a byte may enter only in the cycle the record leaves.
  assign bus_io.in_ready = (state_q != StOut) | bus_io.out_ready;
  assign in_fire         = bus_io.in_valid & bus_io.in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    a_d      = a_q;
    imm_d    = imm_q;
    ill_d    = ill_q;
    load_opc = 1'b0;

    unique case (state_q)
      StOpc: begin
        if (in_fire) load_opc = 1'b1;
      end
      StImm: begin
        if (in_fire) begin
          for (int unsigned k = 0; k < IMM_BYTES; k++) begin
            if (cnt_q == CntW'(k)) imm_d[8*k +: 8] = bus_io.in_byte;
          end
          if (cnt_q == LastCnt) state_d = StOut;
          else                  cnt_d   = cnt_q + CntW'(1);
        end
      end
      StOut: begin
        if (bus_io.out_ready) begin
          // Back-to-back: the next opcode is decoded in the same cycle the record leaves.
          if (bus_io.in_valid) load_opc = 1'b1;
          else                 state_d  = StOpc;
        end
      end
      default: state_d = StOpc;
    endcase

    if (load_opc) begin
      idx_d    = decode_idx(bus_io.in_byte);
      onehot_d = 23'd1 << idx_d;
      a_d      = bus_io.in_byte[3:0];
      imm_d    = '0;
      ill_d    = decode_ill(bus_io.in_byte);
      cnt_d    = '0;
      state_d  = IMM_MASK[bus_io.in_byte[7:4]] ? StImm : StOut;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StOpc;
      cnt_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
      a_q      <= '0;
      imm_q    <= '0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      a_q      <= a_d;
      imm_q    <= imm_d;
      ill_q    <= ill_d;
    end
  end

  assign bus_io.out_valid = (state_q == StOut);
  assign bus_io.op_onehot = onehot_q;
  assign bus_io.op_index  = idx_q;
  assign bus_io.a_field   = a_q;
  assign bus_io.imm       = imm_q;
  assign bus_io.illegal   = ill_q;

endmodule

// File: tb/tb_stream_opcode_decoder.sv
// Bench for stream_opcode_decoder: a strict and a non-strict instance see the same stream
// and handshake; both are compared every cycle against a byte-level reference model.
module tb_stream_opcode_decoder;

  localparam logic [15:0] Mask     = 16'h0108;
  localparam int unsigned ImmBytes = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       out_ready = 1'b0;

  stream_opcode_decoder_if #(.IMM_BYTES(ImmBytes)) bus_s ();
  stream_opcode_decoder_if #(.IMM_BYTES(ImmBytes)) bus_l ();

  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_byte   = in_byte;
  assign bus_s.out_ready = out_ready;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_byte   = in_byte;
  assign bus_l.out_ready = out_ready;

  stream_opcode_decoder #(.IMM_MASK(Mask), .IMM_BYTES(ImmBytes), .STRICT(1'b1)) u_dut_strict (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_s)
  );

  stream_opcode_decoder #(.IMM_MASK(Mask), .IMM_BYTES(ImmBytes), .STRICT(1'b0)) u_dut_lax (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus_l)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    int unsigned a;
    int unsigned imm;
    bit          ill;
  } rec_t;

  rec_t        exp_q[$];
  logic [7:0]  pend_q[$];
  int unsigned log_idx[$];
  int unsigned log_a[$];
  int unsigned log_imm[$];
  bit          log_ill_s[$];
  bit          log_ill_l[$];
  bit          col_active = 1'b0;
  int unsigned col_got = 0;
  rec_t        col_rec;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Index = number of slots used by all lower majors + sub-op within this major.
  function automatic int unsigned ref_idx(input logic [7:0] b);
    int unsigned width[16] = '{1, 4, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 1, 4};
    int unsigned maj = int'(b[7:4]);
    int unsigned base = 0;
    int unsigned sub;
    for (int unsigned m = 0; m < maj; m++) base += width[m];
    sub = (width[maj] == 4) ? int'(b) % 4 : (width[maj] == 2) ? int'(b) % 2 : 0;
    return base + sub;
  endfunction

  function automatic bit ref_ill(input logic [7:0] b);
    int unsigned maj = int'(b[7:4]);
    if (maj == 1 || maj == 15) return (b & 8'h0C) != 8'h00;
    if (maj == 12)             return (b & 8'h0E) != 8'h00;
    return 1'b0;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (col_active) begin
      col_rec.imm = col_rec.imm + (32'(b) << (8 * col_got));
      col_got++;
      if (col_got == ImmBytes) begin
        exp_q.push_back(col_rec);
        col_active = 1'b0;
      end
    end else begin
      col_rec = '{ref_idx(b), 32'(b[3:0]), 0, ref_ill(b)};
      if (Mask[b[7:4]]) begin
        col_active = 1'b1;
        col_got    = 0;
      end else begin
        exp_q.push_back(col_rec);
      end
    end
  endtask

  task automatic check_fields(input rec_t r);
    check("op_index", 32'(bus_s.op_index), r.idx);
    check("op_onehot", 32'(bus_s.op_onehot), 32'd1 << r.idx);
    check("onehot_prop", 32'($onehot(bus_s.op_onehot)), 1);
    check("a_field", 32'(bus_s.a_field), r.a);
    check("imm", 32'(bus_s.imm), r.imm);
    check("illegal_strict", 32'(bus_s.illegal), 32'(r.ill));
    check("op_index_lax", 32'(bus_l.op_index), r.idx);
    check("imm_lax", 32'(bus_l.imm), r.imm);
    check("illegal_lax", 32'(bus_l.illegal), 0);
  endtask

  // One clock: observe at negedge, update the model, then advance to posedge+1.
  task automatic step();
    bit exp_valid;
    bit exp_ready;
    @(negedge clk);
    exp_valid = exp_q.size() > 0;
    exp_ready = !exp_valid || out_ready;
    check("out_valid", 32'(bus_s.out_valid), 32'(exp_valid));
    check("out_valid_lax", 32'(bus_l.out_valid), 32'(exp_valid));
    check("in_ready", 32'(bus_s.in_ready), 32'(exp_ready));
    check("in_ready_lax", 32'(bus_l.in_ready), 32'(exp_ready));
    if (exp_valid) begin
      check_fields(exp_q[0]);
      if (out_ready) begin
        void'(exp_q.pop_front());
        log_idx.push_back(32'(bus_s.op_index));
        log_a.push_back(32'(bus_s.a_field));
        log_imm.push_back(32'(bus_s.imm));
        log_ill_s.push_back(bus_s.illegal);
        log_ill_l.push_back(bus_l.illegal);
      end
    end
    if (in_valid && exp_ready) begin
      model_byte(in_byte);
      if (pend_q.size() > 0) void'(pend_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int unsigned vpct, input int unsigned rpct,
                            output int unsigned cyc);
    cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 5000) begin
      in_valid  = (pend_q.size() > 0) && ($urandom_range(99) < vpct);
      in_byte   = (pend_q.size() > 0) ? pend_q[0] : 8'($urandom);
      out_ready = $urandom_range(99) < rpct;
      step();
      cyc++;
    end
    check("drain_in_budget", 32'(cyc < 5000), 1);
    in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log_idx.delete();
    log_a.delete();
    log_imm.delete();
    log_ill_s.delete();
    log_ill_l.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus_s.out_valid | bus_l.out_valid), 0);
    check({tag, "_onehot"}, 32'(bus_s.op_onehot | bus_l.op_onehot), 0);
    check({tag, "_index"}, 32'(bus_s.op_index | bus_l.op_index), 0);
    check({tag, "_a_field"}, 32'(bus_s.a_field | bus_l.a_field), 0);
    check({tag, "_imm"}, 32'(bus_s.imm | bus_l.imm), 0);
    check({tag, "_illegal"}, 32'(bus_s.illegal | bus_l.illegal), 0);
    check({tag, "_in_ready"}, 32'(bus_s.in_ready & bus_l.in_ready), 1);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned t1_idx[4] = '{0, 4, 21, 16};
    int unsigned t3_idx[3] = '{5, 7, 9};
    int unsigned t4_idx[3] = '{1, 15, 19};
    logic [7:0] op;

    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back opcodes without immediates.
    clear_logs();
    pend_q = '{8'h00, 8'h13, 8'hF2, 8'hC1};
    run_stream(100, 100, cyc);
    check("t1_cycles", cyc, 5);
    check("t1_count", log_idx.size(), 4);
    for (int i = 0; i < 4 && i < log_idx.size(); i++) check("t1_idx", log_idx[i], t1_idx[i]);

    // Two-byte little-endian immediate.
    clear_logs();
    pend_q = '{8'h85, 8'h34, 8'h12};
    run_stream(100, 100, cyc);
    check("t2_cycles", cyc, 4);
    check("t2_count", log_idx.size(), 1);
    if (log_idx.size() > 0) begin
      check("t2_idx", log_idx[0], 11);
      check("t2_a", log_a[0], 5);
      check("t2_imm", log_imm[0], 32'h1234);
    end

    // Backpressure: record held with a stream pending.
    clear_logs();
    pend_q = '{8'h23, 8'h45, 8'h67};
    for (int i = 0; i < 7; i++) begin
      in_valid  = pend_q.size() > 0;
      in_byte   = pend_q[0];
      out_ready = 1'b0;
      step();
    end
    run_stream(100, 100, cyc);
    check("t3_count", log_idx.size(), 3);
    for (int i = 0; i < 3 && i < log_idx.size(); i++) check("t3_idx", log_idx[i], t3_idx[i]);

    // Strict-mode illegal flags.
    clear_logs();
    pend_q = '{8'h1C, 8'hC2, 8'hFC};
    run_stream(100, 100, cyc);
    check("t4_count", log_idx.size(), 3);
    for (int i = 0; i < 3 && i < log_idx.size(); i++) begin
      check("t4_idx", log_idx[i], t4_idx[i]);
      check("t4_ill_strict", 32'(log_ill_s[i]), 1);
      check("t4_ill_lax", 32'(log_ill_l[i]), 0);
    end

    // Asynchronous reset after the first of two immediate bytes.
    clear_logs();
    in_valid = 1'b1; in_byte = 8'h85; out_ready = 1'b1;
    step();
    in_byte = 8'h34;
    step();
    in_valid = 1'b0;
    check("t5_latched_idx", 32'(bus_s.op_index), 11);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t5");
    exp_q.delete();
    pend_q.delete();
    col_active = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    pend_q = '{8'h12};
    run_stream(100, 100, cyc);
    check("t5_count", log_idx.size(), 1);
    if (log_idx.size() > 0) begin
      check("t5_idx", log_idx[0], 3);
      check("t5_a", log_a[0], 2);
      check("t5_imm", log_imm[0], 0);
    end

    // Sweep every opcode byte under random handshake timing.
    clear_logs();
    for (int b = 0; b < 256; b++) begin
      op = 8'(b);
      pend_q.push_back(op);
      if (Mask[op[7:4]]) for (int k = 0; k < ImmBytes; k++) pend_q.push_back(8'($urandom));
    end
    run_stream(70, 70, cyc);
    check("t6_count", log_idx.size(), 256);

    // Random instruction stream.
    for (int n = 0; n < 300; n++) begin
      op = 8'($urandom);
      pend_q.push_back(op);
      if (Mask[op[7:4]]) for (int k = 0; k < ImmBytes; k++) pend_q.push_back(8'($urandom));
    end
    run_stream(60, 50, cyc);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
